// File: rtl/linebuffer_2x2_stream_ctrl.sv
// 2x2 sliding-window line buffer for the max-pool path.
// Accepts a valid-qualified CH-lane pixel stream with runtime width/height,
// keeps one row of history in a line memory and emits 2x2 windows at stride 1
// or stride 2, with a frame-end flag on the last window.
module linebuffer_2x2_stream_ctrl #(
  parameter int DW    = 8,
  parameter int CH    = 1,
  parameter int MAX_W = 256,
  parameter int CW    = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CW-1:0]          cfg_width,
  input  logic [CW-1:0]          cfg_height,
  input  logic                   cfg_stride2,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [DW*CH-1:0]       in_data,
  output logic                   out_valid,
  output logic                   out_eof,
  output logic [4*DW*CH-1:0]     out_win,
  output logic                   cfg_err
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int PW = DW * CH;

  typedef enum logic {IDLE, RUN} state_t;

  // Out-of-range widths fall back to the full line memory depth.
  function automatic logic [CW-1:0] sat_width(input logic [CW-1:0] w);
    if (w < CW'(2) || w > CW'(MAX_W)) return CW'(MAX_W);
    return w;
  endfunction

  // A frame needs at least two rows to form any window.
  function automatic logic [CW-1:0] sat_height(input logic [CW-1:0] h);
    if (h < CW'(2)) return CW'(2);
    return h;
  endfunction

  function automatic logic cfg_bad(input logic [CW-1:0] w, input logic [CW-1:0] h);
    return (w < CW'(2)) || (w > CW'(MAX_W)) || (h < CW'(2));
  endfunction

  state_t          state;
  logic [CW-1:0]   col_q, row_q, w_q, h_q;
  logic            s2_q;
  logic [PW-1:0]   mem [MAX_W];
  logic [PW-1:0]   tr_q, br_q;
  logic            vld_p1, eof_p1;
  logic [4*PW-1:0] win_p1;

  // ---- stage p0: beat qualification, effective cfg/position, memory read ----
  logic            start_p0, beat_p0, s2_p0;
  logic [CW-1:0]   w_p0, h_p0, col_p0, row_p0, ecol_p0, erow_p0;
  logic [PW-1:0]   rd_p0;
  logic            win_ok_p0, eof_ok_p0, col_last_p0, row_last_p0;
  logic [4*PW-1:0] win_p0;

  assign start_p0 = in_valid && in_sof;
  assign beat_p0  = in_valid && (in_sof || state == RUN);
  assign w_p0     = start_p0 ? sat_width(cfg_width)   : w_q;
  assign h_p0     = start_p0 ? sat_height(cfg_height) : h_q;
  assign s2_p0    = start_p0 ? cfg_stride2 : s2_q;
  assign col_p0   = start_p0 ? '0 : col_q;
  assign row_p0   = start_p0 ? '0 : row_q;
  assign rd_p0    = mem[col_p0[AW-1:0]];

  assign col_last_p0 = (col_p0 == w_p0 - CW'(1));
  assign row_last_p0 = (row_p0 == h_p0 - CW'(1));

  // Window gating and the position of the last window emitted in this frame.
  always_comb begin
    win_ok_p0 = (row_p0 != '0) && (col_p0 != '0) &&
                (!s2_p0 || (row_p0[0] && col_p0[0]));
    ecol_p0 = w_p0 - CW'(1);
    erow_p0 = h_p0 - CW'(1);
    if (s2_p0 && !ecol_p0[0]) ecol_p0 = ecol_p0 - CW'(1);
    if (s2_p0 && !erow_p0[0]) erow_p0 = erow_p0 - CW'(1);
    eof_ok_p0 = win_ok_p0 && (col_p0 == ecol_p0) && (row_p0 == erow_p0);
  end

  // Assemble the post-shift window per lane: {br, bl, tr, tl}.
  always_comb begin
    win_p0 = '0;
    for (int c = 0; c < CH; c++) begin
      win_p0[c*4*DW        +: DW] = tr_q[c*DW +: DW];
      win_p0[c*4*DW + DW   +: DW] = rd_p0[c*DW +: DW];
      win_p0[c*4*DW + 2*DW +: DW] = br_q[c*DW +: DW];
      win_p0[c*4*DW + 3*DW +: DW] = in_data[c*DW +: DW];
    end
  end

  // ---- stage p1: registered control, counters and window output ----
  // Frame FSM, position counters, latched cfg and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= CW'(MAX_W);
      h_q     <= CW'(2);
      s2_q    <= 1'b0;
      cfg_err <= 1'b0;
      vld_p1  <= 1'b0;
      eof_p1  <= 1'b0;
      win_p1  <= '0;
    end else begin
      vld_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      if (start_p0) begin
        w_q     <= w_p0;
        h_q     <= h_p0;
        s2_q    <= s2_p0;
        cfg_err <= cfg_bad(cfg_width, cfg_height);
      end
      if (beat_p0) begin
        if (win_ok_p0) begin
          vld_p1 <= 1'b1;
          eof_p1 <= eof_ok_p0;
          win_p1 <= win_p0;
        end
        if (col_last_p0) begin
          col_q <= '0;
          if (row_last_p0) begin
            row_q <= '0;
            state <= IDLE;
          end else begin
            row_q <= row_p0 + CW'(1);
            state <= RUN;
          end
        end else begin
          col_q <= col_p0 + CW'(1);
          row_q <= row_p0;
          state <= RUN;
        end
      end
    end
  end

  // Line memory (read-before-write at col) and the right-hand window column.
  always_ff @(posedge clk) begin
    if (beat_p0) begin
      mem[col_p0[AW-1:0]] <= in_data;
      tr_q                <= rd_p0;
      br_q                <= in_data;
    end
  end

  assign out_valid = vld_p1;
  assign out_eof   = eof_p1;
  assign out_win   = win_p1;

endmodule

// File: tb/tb_linebuffer_2x2_stream_ctrl.sv
// Scoreboard bench for linebuffer_2x2_stream_ctrl (CH=2, lane1 = ~lane0).
module tb_linebuffer_2x2_stream_ctrl;

  localparam int DW = 8, CH = 2, MAX_W = 256, CW = 9;
  localparam int WW = 4 * DW * CH;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   cfg_width, cfg_height;
  logic            cfg_stride2, in_valid, in_sof;
  logic [DW*CH-1:0] in_data;
  logic            out_valid, out_eof, cfg_err;
  logic [WW-1:0]   out_win;

  linebuffer_2x2_stream_ctrl #(.DW(DW), .CH(CH), .MAX_W(MAX_W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_stride2(cfg_stride2), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_eof(out_eof),
    .out_win(out_win), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] win;
    logic          eof;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            cyc = 0;
  int            n_assert = 0;
  int            n_fail = 0;
  logic [WW-1:0] last_win = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(int base, int r, int c, int w);
    return 8'(base + r * w + c);
  endfunction

  function automatic logic [WW-1:0] mk_win(logic [7:0] tl, logic [7:0] tr,
                                           logic [7:0] bl, logic [7:0] br);
    logic [31:0] l0;
    l0 = {br, bl, tr, tl};
    return {~l0, l0};
  endfunction

  task automatic check(string tag, logic [WW-1:0] obs, logic [WW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Output monitor: every expected window must appear exactly on its due cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      last_win = e.win;
      n_assert++;
      assert (out_valid === 1'b1) else begin
        n_fail++; $error("FAIL out_valid observed=%b expected=1", out_valid);
      end
      n_assert++;
      assert (out_win === e.win) else begin
        n_fail++; $error("FAIL out_win observed=%h expected=%h", out_win, e.win);
      end
      n_assert++;
      assert (out_eof === e.eof) else begin
        n_fail++; $error("FAIL out_eof observed=%b expected=%b", out_eof, e.eof);
      end
    end else begin
      n_assert++;
      assert (out_valid === 1'b0) else begin
        n_fail++; $error("FAIL spurious_valid observed=%b expected=0 cyc=%0d", out_valid, cyc);
      end
    end
  end

  // Drive one frame (or its first max_beats beats) and push expected windows.
  // Non-sof beats present mid_w on cfg_width and an inverted stride on
  // cfg_stride2, which the DUT must ignore.
  task automatic run_frame(int w_port, int h_port, int w_eff, int h_eff, bit s2,
                           bit gaps, int mid_w, int max_beats, int base);
    int   n_win, k_win, g;
    exp_t x;
    bit   complete;
    n_win    = s2 ? (w_eff / 2) * (h_eff / 2) : (w_eff - 1) * (h_eff - 1);
    complete = (max_beats >= w_eff * h_eff);
    k_win    = 0;
    for (int r = 0; r < h_eff; r++) begin
      for (int c = 0; c < w_eff; c++) begin
        if (r * w_eff + c >= max_beats) break;
        if (gaps) begin
          g = $urandom_range(0, 2);
          repeat (g) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
          end
        end
        @(posedge clk); #1;
        in_valid    = 1'b1;
        in_sof      = (r == 0 && c == 0);
        cfg_width   = in_sof ? CW'(w_port) : CW'(mid_w);
        cfg_height  = CW'(h_port);
        cfg_stride2 = in_sof ? s2 : ~s2;
        in_data     = {~pix(base, r, c, w_eff), pix(base, r, c, w_eff)};
        if (r >= 1 && c >= 1 && (!s2 || (r % 2 == 1 && c % 2 == 1))) begin
          k_win++;
          x.win = mk_win(pix(base, r-1, c-1, w_eff), pix(base, r-1, c, w_eff),
                         pix(base, r, c-1, w_eff), pix(base, r, c, w_eff));
          x.eof = complete && (k_win == n_win);
          x.due = cyc + 1;
          sb.push_back(x);
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("scoreboard_drained", WW'(sb.size()), '0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    cfg_width = CW'(4); cfg_height = CW'(4); cfg_stride2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid",   WW'(out_valid), '0);
    check("reset_eof",     WW'(out_eof),   '0);
    check("reset_win",     out_win,        '0);
    check("reset_cfg_err", WW'(cfg_err),   '0);

    // T1: 4x4 stride2, pixels 0..15
    run_frame(4, 4, 4, 4, 1'b1, 1'b0, 4, 1 << 20, 0);
    drain();
    check("t1_last_win", last_win, mk_win(8'd10, 8'd11, 8'd14, 8'd15));
    // T2: same frame at stride1
    run_frame(4, 4, 4, 4, 1'b0, 1'b0, 4, 1 << 20, 0);
    drain();
    // T3: T1 with random idle gaps; out_win must hold afterwards
    run_frame(4, 4, 4, 4, 1'b1, 1'b1, 4, 1 << 20, 0);
    drain();
    repeat (3) @(posedge clk);
    #1 check("t3_win_hold", out_win, mk_win(8'd10, 8'd11, 8'd14, 8'd15));
    // Odd geometry at stride2: trailing row/column produce no window
    run_frame(5, 5, 5, 5, 1'b1, 1'b0, 5, 1 << 20, 40);
    drain();
    // T4: full-width line, two rows, stride2
    run_frame(256, 2, 256, 2, 1'b1, 1'b0, 256, 1 << 20, 7);
    drain();
    check("t4_cfg_err", WW'(cfg_err), '0);
    // T5: illegal width latched as MAX_W
    run_frame(1, 2, 256, 2, 1'b1, 1'b0, 4, 1 << 20, 3);
    drain();
    check("t5_cfg_err_set", WW'(cfg_err), WW'(1));
    // T5 cont: legal sof clears it; mid-frame width change ignored
    run_frame(4, 4, 4, 4, 1'b0, 1'b0, 2, 1 << 20, 100);
    drain();
    check("t5_cfg_err_clr", WW'(cfg_err), '0);
    // Height below 2 is latched as 2
    run_frame(4, 1, 4, 2, 1'b0, 1'b0, 4, 1 << 20, 60);
    drain();
    check("t5_height_err", WW'(cfg_err), WW'(1));
    // T6: frame aborted at row 2 by a new sof
    run_frame(4, 4, 4, 4, 1'b0, 1'b0, 4, 8, 20);
    run_frame(4, 4, 4, 4, 1'b0, 1'b0, 4, 1 << 20, 50);
    drain();
    check("t6_cfg_err", WW'(cfg_err), '0);
    // T6 cont: reset pulse mid-frame, then beats without sof are dropped
    run_frame(4, 4, 4, 4, 1'b0, 1'b0, 4, 6, 90);
    drain();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_valid", WW'(out_valid), '0);
    check("rst_win",   out_win,        '0);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_data = 16'(k * 3 + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_drop_win", out_win, '0);
    // A fresh sof after the dropped beats starts cleanly
    run_frame(4, 4, 4, 4, 1'b1, 1'b0, 4, 1 << 20, 200);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
